// File: rtl/four_12_12_pkg.sv
// -----------------------------------------------------------------------------
// four_12_12_pkg
// Shared definitions for the four_12_12 pipeline: the float_24_8 word type,
// the lane/word geometry and the burst-length clamp that the stage-0 result
// serializer and the stage-1 data FIFO controller must agree on.
// -----------------------------------------------------------------------------
package four_12_12_pkg;

  localparam int LANES  = 12;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 8;
  localparam int LEN_W  = 4;

  // 24-bit mantissa / 8-bit exponent packed into one 32-bit word
  typedef logic [WORD_W-1:0] float_24_8;

  // Effective burst length: a request of 0 or anything above the lane count
  // means "the whole vector".
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req,
                                                 input logic [LEN_W-1:0] max_len);
    logic [LEN_W-1:0] len;
    if ((req == 4'd0) || (req > max_len)) begin
      len = max_len;
    end else begin
      len = req;
    end
    return len;
  endfunction

endpackage

// File: rtl/four_12_12_st0_vec_buf.sv
// -----------------------------------------------------------------------------
// four_12_12_st0_vec_buf
// Two-entry ping-pong store for stage-0 result vectors. Each entry keeps the
// full LANES-wide vector and its effective burst length.
//
// Ports:
//   clk, reset      clock / asynchronous active-low reset
//   push            write push_vec/push_len into entry[wr_ptr], toggle wr_ptr
//   push_vec        LANES*WORD_W vector to store
//   push_len        effective length (already clamped) stored with the vector
//   pop             free entry[rd_ptr], toggle rd_ptr
//   rd_vec, rd_len  contents of entry[rd_ptr]
//   occupancy       number of valid entries (0..2)
//
// The caller never pushes when occupancy is 2 and never pops when it is 0.
// With occupancy 1, wr_ptr and rd_ptr differ, so a simultaneous push and pop
// touch different entries and occupancy stays the same.
// -----------------------------------------------------------------------------
module four_12_12_st0_vec_buf
  import four_12_12_pkg::*;
#(
  parameter int LANES  = four_12_12_pkg::LANES,
  parameter int WORD_W = four_12_12_pkg::WORD_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [LANES*WORD_W-1:0] push_vec,
  input  logic [3:0]              push_len,
  input  logic                    pop,
  output logic [LANES*WORD_W-1:0] rd_vec,
  output logic [3:0]              rd_len,
  output logic [1:0]              occupancy
);

  localparam int VEC_W = LANES * WORD_W;

  logic [VEC_W-1:0] vec_r [2];
  logic [3:0]       len_r [2];
  logic [1:0]       valid_r;
  logic             wr_ptr_r;
  logic             rd_ptr_r;

  logic [1:0]       push_mask_s;
  logic [1:0]       pop_mask_s;
  logic [1:0]       valid_next_s;

  // One-hot set/clear masks for the entry valid bits.
  always_comb begin
    push_mask_s  = 2'b00;
    pop_mask_s   = 2'b00;
    push_mask_s  = push ? (wr_ptr_r ? 2'b10 : 2'b01) : 2'b00;
    pop_mask_s   = pop  ? (rd_ptr_r ? 2'b10 : 2'b01) : 2'b00;
    valid_next_s = (valid_r | push_mask_s) & ~pop_mask_s;
  end

  // Entry storage, valid bits and the two ping-pong pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_r[0] <= '0;
      vec_r[1] <= '0;
      len_r[0] <= 4'd0;
      len_r[1] <= 4'd0;
      valid_r  <= 2'b00;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      if (push) begin
        vec_r[wr_ptr_r] <= push_vec;
        len_r[wr_ptr_r] <= push_len;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      valid_r <= valid_next_s;
    end
  end

  assign rd_vec    = vec_r[rd_ptr_r];
  assign rd_len    = len_r[rd_ptr_r];
  assign occupancy = {1'b0, valid_r[0]} + {1'b0, valid_r[1]};

endmodule

// File: rtl/four_12_12_st0_result_serializer.sv
// -----------------------------------------------------------------------------
// four_12_12_st0_result_serializer
// Stage-0 output serializer. Accepts one LANES-wide result vector per in_vld/
// in_rdy handshake into a two-entry ping-pong buffer and streams each vector
// one word per cycle on the stage_1_data valid/ready interface, marking the
// first and last word of every burst and counting completed vectors.
//
// Ports:
//   clk, reset          clock / asynchronous active-low reset
//   in_data, in_vld     result vector (lane k = bits [k*WORD_W +: WORD_W])
//   in_rdy              buffer has a free entry
//   out_length          words per burst, sampled with each accepted vector
//   stage_1_data*       word, valid, first, last, ready of the output stream
//   vector_done         one-cycle pulse the cycle after a last word is taken
//   vector_count        completed vectors, wraps modulo 2^CNT_W
//   busy                at least one vector is buffered
//
// All outputs are decoded from registered state only, so in_rdy has no
// combinational path from stage_1_data_rdy: a freed slot shows up on in_rdy
// the cycle after the last word is accepted.
// -----------------------------------------------------------------------------
module four_12_12_st0_result_serializer
  import four_12_12_pkg::*;
#(
  parameter int LANES  = four_12_12_pkg::LANES,
  parameter int WORD_W = four_12_12_pkg::WORD_W,
  parameter int CNT_W  = four_12_12_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES*WORD_W-1:0] in_data,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [3:0]              out_length,
  output logic [WORD_W-1:0]       stage_1_data,
  output logic                    stage_1_data_vld,
  output logic                    stage_1_data_fst,
  output logic                    stage_1_data_lst,
  input  logic                    stage_1_data_rdy,
  output logic                    vector_done,
  output logic [CNT_W-1:0]        vector_count,
  output logic                    busy
);

  localparam logic [3:0] LANES_L = 4'(LANES);

  logic [LANES*WORD_W-1:0] rd_vec_s;
  logic [3:0]              rd_len_s;
  logic [1:0]              occupancy_s;
  logic [3:0]              push_len_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    acc_s;
  logic                    vld_s;
  logic                    fst_s;
  logic                    lst_s;
  logic [WORD_W-1:0]       lane_s [LANES];
  logic [WORD_W-1:0]       word_s;
  logic [3:0]              lane_idx_next_s;

  logic [3:0]              lane_idx_r;
  logic [CNT_W-1:0]        vector_count_r;
  logic                    vector_done_r;

  assign push_len_s = clamp_len(out_length, LANES_L);
  assign push_s     = in_vld & in_rdy;

  four_12_12_st0_vec_buf #(
    .LANES  (LANES),
    .WORD_W (WORD_W)
  ) u_vec_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_vec  (in_data),
    .push_len  (push_len_s),
    .pop       (pop_s),
    .rd_vec    (rd_vec_s),
    .rd_len    (rd_len_s),
    .occupancy (occupancy_s)
  );

  // Split the head vector into lanes for the word mux.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_s[k] = rd_vec_s[k*WORD_W +: WORD_W];
    end
  end

  // Output word mux and burst flags; data is forced to zero while idle.
  always_comb begin
    word_s = '0;
    vld_s  = (occupancy_s != 2'd0);
    if (vld_s && (lane_idx_r < LANES_L)) begin
      word_s = lane_s[lane_idx_r];
    end else begin
      word_s = '0;
    end
    fst_s = vld_s & (lane_idx_r == 4'd0);
    lst_s = vld_s & (lane_idx_r == (rd_len_s - 4'd1));
    acc_s = vld_s & stage_1_data_rdy;
    pop_s = acc_s & lst_s;
  end

  // Next lane index: advance on every accepted word, wrap after the last one.
  always_comb begin
    lane_idx_next_s = lane_idx_r;
    if (acc_s) begin
      if (lst_s) begin
        lane_idx_next_s = 4'd0;
      end else begin
        lane_idx_next_s = lane_idx_r + 4'd1;
      end
    end else begin
      lane_idx_next_s = lane_idx_r;
    end
  end

  // Lane index, completion pulse and completed-vector counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_idx_r     <= 4'd0;
      vector_count_r <= '0;
      vector_done_r  <= 1'b0;
    end else begin
      lane_idx_r    <= lane_idx_next_s;
      vector_done_r <= pop_s;
      if (pop_s) begin
        vector_count_r <= vector_count_r + CNT_W'(1);
      end
    end
  end

  assign in_rdy           = (occupancy_s != 2'd2);
  assign stage_1_data     = word_s;
  assign stage_1_data_vld = vld_s;
  assign stage_1_data_fst = fst_s;
  assign stage_1_data_lst = lst_s;
  assign vector_done      = vector_done_r;
  assign vector_count     = vector_count_r;
  assign busy             = vld_s;

endmodule

// File: tb/tb_four_12_12_st0_result_serializer.sv
// -----------------------------------------------------------------------------
// Bench for four_12_12_st0_result_serializer. A queue of buffered vectors
// (with their clamped lengths) and a position within the head vector form the
// reference; every cycle all outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_four_12_12_st0_result_serializer;

  localparam int L = 12;
  localparam int W = 32;

  logic           clk;
  logic           reset;
  logic [L*W-1:0] in_data;
  logic           in_vld;
  logic           in_rdy;
  logic [3:0]     out_length;
  logic [W-1:0]   stage_1_data;
  logic           stage_1_data_vld;
  logic           stage_1_data_fst;
  logic           stage_1_data_lst;
  logic           stage_1_data_rdy;
  logic           vector_done;
  logic [7:0]     vector_count;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [L*W-1:0] mq [$];
  int             ml [$];
  int             mpos   = 0;
  int             mcount = 0;
  bit             mdone  = 1'b0;
  bit             last_push = 1'b0;

  four_12_12_st0_result_serializer dut (
    .clk              (clk),
    .reset            (reset),
    .in_data          (in_data),
    .in_vld           (in_vld),
    .in_rdy           (in_rdy),
    .out_length       (out_length),
    .stage_1_data     (stage_1_data),
    .stage_1_data_vld (stage_1_data_vld),
    .stage_1_data_fst (stage_1_data_fst),
    .stage_1_data_lst (stage_1_data_lst),
    .stage_1_data_rdy (stage_1_data_rdy),
    .vector_done      (vector_done),
    .vector_count     (vector_count),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ml.delete();
    mpos   = 0;
    mcount = 0;
    mdone  = 1'b0;
    last_push = 1'b0;
  endtask

  task automatic check_outputs();
    logic [L*W-1:0] head;
    bit             e_vld;
    logic [31:0]    e_data;
    e_vld  = (mq.size() > 0);
    e_data = 32'd0;
    if (e_vld) begin
      head   = mq[0];
      e_data = head[mpos*W +: W];
    end
    chk("data",   stage_1_data, e_data);
    chk("vld",    32'(stage_1_data_vld), 32'(e_vld));
    chk("fst",    32'(stage_1_data_fst), 32'(e_vld && (mpos == 0)));
    chk("lst",    32'(stage_1_data_lst), 32'(e_vld && (mpos == ml[0] - 1)));
    chk("in_rdy", 32'(in_rdy), 32'(mq.size() < 2));
    chk("busy",   32'(busy), 32'(e_vld));
    chk("done",   32'(vector_done), 32'(mdone));
    chk("count",  32'(vector_count), 32'(mcount % 256));
  endtask

  // Advance the reference by one clock using the inputs that were applied.
  task automatic model_update();
    bit p;
    bit a;
    int len;
    p = in_vld && (mq.size() < 2);
    a = (mq.size() > 0) && stage_1_data_rdy;
    mdone = 1'b0;
    if (a) begin
      if (mpos == ml[0] - 1) begin
        void'(mq.pop_front());
        void'(ml.pop_front());
        mpos   = 0;
        mcount = mcount + 1;
        mdone  = 1'b1;
      end else begin
        mpos = mpos + 1;
      end
    end
    if (p) begin
      len = ((out_length == 4'd0) || (out_length > 4'd12)) ? 12 : int'(out_length);
      mq.push_back(in_data);
      ml.push_back(len);
    end
    last_push = p;
  endtask

  task automatic step(input logic v, input logic [L*W-1:0] d, input logic [3:0] len, input logic r);
    in_vld           = v;
    in_data          = d;
    out_length       = len;
    stage_1_data_rdy = r;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [L*W-1:0] seq_vec(input logic [31:0] base);
    logic [L*W-1:0] v;
    for (int k = 0; k < L; k++) v[k*W +: W] = base + 32'(k);
    return v;
  endfunction

  function automatic logic [L*W-1:0] rand_vec();
    logic [L*W-1:0] v;
    for (int k = 0; k < L; k++) v[k*W +: W] = $urandom;
    return v;
  endfunction

  initial begin
    logic [L*W-1:0] v2;
    reset = 1'b0;
    in_vld = 1'b0;
    in_data = '0;
    out_length = 4'd12;
    stage_1_data_rdy = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single full vector, continuous ready
    step(1'b1, seq_vec(32'h100), 4'd12, 1'b1);
    repeat (14) step(1'b0, '0, 4'd12, 1'b1);
    chk("single_count", 32'(vector_count), 32'd1);

    // backpressure with a 4-word burst: rdy 1,0,0,1,...
    step(1'b1, rand_vec(), 4'd4, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, '0, 4'd4, ((i % 3) == 0) ? 1'b1 : 1'b0);

    // full buffer: three vectors back to back with rdy low
    step(1'b1, rand_vec(), 4'd12, 1'b0);
    step(1'b1, rand_vec(), 4'd12, 1'b0);
    v2 = rand_vec();
    step(1'b1, v2, 4'd12, 1'b0);
    chk("full_in_rdy", 32'(in_rdy), 32'd0);
    for (int i = 0; (i < 40) && !last_push; i++) step(1'b1, v2, 4'd12, 1'b1);
    chk("third_pushed", 32'(last_push), 32'd1);
    repeat (28) step(1'b0, '0, 4'd12, 1'b1);

    // length clamp: 0 and 15 give 12 words, 1 gives a single fst+lst word
    step(1'b1, rand_vec(), 4'd0, 1'b1);
    repeat (12) step(1'b0, '0, 4'd3, 1'b1);
    step(1'b1, rand_vec(), 4'd15, 1'b1);
    repeat (12) step(1'b0, '0, 4'd3, 1'b1);
    step(1'b1, rand_vec(), 4'd1, 1'b1);
    repeat (3) step(1'b0, '0, 4'd12, 1'b1);

    // push in the same cycle as the last-word accept of a 3-word burst
    step(1'b1, rand_vec(), 4'd3, 1'b1);
    step(1'b0, '0, 4'd3, 1'b1);
    step(1'b0, '0, 4'd3, 1'b1);
    step(1'b1, rand_vec(), 4'd3, 1'b1);
    chk("simul_fst", 32'(stage_1_data_fst), 32'd1);
    repeat (4) step(1'b0, '0, 4'd3, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), rand_vec(), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    repeat (30) step(1'b0, '0, 4'd12, 1'b1);

    // reset in the middle of a burst at lane 5
    step(1'b1, rand_vec(), 4'd12, 1'b1);
    repeat (5) step(1'b0, '0, 4'd12, 1'b1);
    chk("pre_reset_pos", 32'(mpos), 32'd5);
    reset = 1'b0;
    #1;
    chk("rst_vld",    32'(stage_1_data_vld), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_count",  32'(vector_count), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, seq_vec(32'h200), 4'd5, 1'b1);
    repeat (7) step(1'b0, '0, 4'd12, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/four_12_12_st0_result_serializer.md
Name: four_12_12_st0_result_serializer

Overview:
- Stage-0 output serializer. Captures one LANES-wide result vector per handshake from the stage-0 neuron array and buffers up to two vectors (ping-pong).
- Streams each vector one word per cycle onto the stage_1_data valid/ready interface consumed by the stage-1 data FIFO controller.
- Marks first/last word of each burst and counts completed vectors.

Parameters:
- LANES, 12, result words per input vector (max burst length).
- WORD_W, 32, bits per word (float_24_8 packing).
- CNT_W, 8, width of the completed-vector counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 asserts).
- in_data  in  LANES*WORD_W  result vector; lane k = bits [k*WORD_W +: WORD_W].
- in_vld  in  1  in_data valid.
- in_rdy  out  1  buffer can accept a vector.
- out_length  in  4  words to emit per vector. Sampled with each accepted vector.
- stage_1_data  out  WORD_W  current word (float_24_8).
- stage_1_data_vld  out  1  word valid.
- stage_1_data_fst  out  1  first word of burst.
- stage_1_data_lst  out  1  last word of burst.
- stage_1_data_rdy  in  1  downstream accepts word.
- vector_done  out  1  one-cycle pulse, cycle after the last word is accepted.
- vector_count  out  CNT_W  completed vectors, wraps modulo 2^CNT_W.
- busy  out  1  any vector buffered.

Behaviour:
- Reset (async assert, sync release) sets the following: entries empty, wr_ptr=rd_ptr=0, lane_idx=0, vector_count=0, vector_done=0. Resulting outputs: in_rdy=1, stage_1_data_vld=0, fst=0, lst=0, busy=0. stage_1_data is don't-care but driven 0.
- Buffer: 2 entries. Each entry holds a vector plus its 4-bit effective length len_eff.
  - len_eff = out_length if 1<=out_length<=LANES, else LANES (0 and 13-15 clamp to LANES).
- occupancy = number of valid entries (0..2). in_rdy = (occupancy<2), combinational from registered state only.
- Push: in_vld & in_rdy writes entry[wr_ptr] and toggles wr_ptr.
- Output is combinational from registered state:
  - stage_1_data = entry[rd_ptr].lane[lane_idx].
  - stage_1_data_vld = (occupancy>0).
  - fst = vld & (lane_idx==0).
  - lst = vld & (lane_idx==len_eff-1).
- Word accept: stage_1_data_vld & stage_1_data_rdy.
  - Not lst: lane_idx += 1.
  - lst: lane_idx <- 0, entry freed, rd_ptr toggles, vector_count += 1. vector_done pulses on the next cycle.
- Simultaneous push and last-word pop: occupancy unchanged.
  - A push when full is impossible (in_rdy=0).
  - When occupancy is 2 and the last word is popped, in_rdy rises the following cycle (no combinational rdy path through stage_1_data_rdy).
- Latency: a vector accepted at cycle t presents word 0 at t+1 if the buffer was empty.
- Throughput: one word per cycle under continuous rdy, with no bubble between bursts when the second entry is full.
- stage_1_data and flags stay stable while vld=1 and rdy=0 (AXI-style hold).
- len_eff=1: fst and lst are asserted together.
- out_length changes mid-burst do not affect buffered vectors.
- Reset mid-burst discards all buffered data. No partial-burst recovery; downstream must also be reset.

Decomposition:
- Shared package four_12_12_pkg:
  - float_24_8 typedef (32-bit).
  - LANES=12, WORD_W=32.
  - clamp-length function used by both this block and the stage-1 controller.
- One sub-module: four_12_12_st0_vec_buf. It is the 2-entry ping-pong store holding pointers, occupancy and per-entry len_eff, with push/pop ports.
- The top holds lane_idx, the output mux, flags and counters.

Test Plan:
- Single vector: lanes=0x100+k, out_length=12, rdy=1 -> 12 consecutive words 0x100..0x10B. fst on word 0, lst on word 11. vector_done one cycle after. vector_count=1.
- Backpressure: out_length=4, rdy toggled 1,0,0,1,... -> each word held stable while rdy=0. Sequence exactly lane0..lane3, no duplicates or drops.
- Full buffer: push 3 vectors back-to-back with rdy=0 -> in_rdy low after the 2nd. Raise rdy -> in_rdy returns the cycle after the 1st burst's lst accept. The 3rd vector is pushed then, and the bursts stream with no gap.
- Length clamp: out_length=0 then 15 -> 12-word bursts. out_length=1 -> fst=lst=1 on the single word.
- Simultaneous: occupancy=1, push on the same cycle as the lst accept -> occupancy stays 1. The next cycle presents word 0 of the new vector with fst=1.
- Reset: assert reset low mid-burst (lane_idx=5) -> immediately vld=0, in_rdy=1, vector_count=0. After release, a new vector starts at lane 0.
